// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared state encoding, default PCF8563 tables and sizing helpers
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_BUSY  = 3'd2,
    ST_IDLE     = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_BUSY  = 3'd5
  } rtc_state_e;

  // PCF8563 seconds, minutes, hours, days, months, years; index 0 in the LSB byte.
  localparam logic [47:0] DEF_REG_ADDRS = 48'h08_07_05_04_03_02;
  // Masks strip the VL flag from seconds and the century bit from months.
  localparam logic [47:0] DEF_REG_MASKS = 48'hFF_1F_3F_3F_7F_7F;
  localparam logic [47:0] DEF_TIME_INIT = 48'h20_06_08_08_00_00;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the shared cycle timer: must hold the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m <= 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rtc_cycle_timer.sv
// rtl/rtc_cycle_timer.sv - clearable cycle counter with terminal-count expiry pulse
// Ports: clk, rst_n (async active-low), clr_i restarts the count at 0,
//        en_i lets it advance, term_i is the terminal count, expire_o pulses
//        for the single cycle in which an enabled count equals term_i.
module rtc_cycle_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;

  assign expire_o = en_i && (count_q == term_i);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rtc_reg_sequencer.sv
// rtl/rtc_reg_sequencer.sv - RTC init/poll sequencer in front of a byte-addressed I2C master
// Purpose: after a power-up wait, writes TIME_INIT to the RTC, then sweeps N_REGS
//   registers every POLL_CYC idle cycles and publishes a masked, coherent snapshot.
//   Each transaction has a watchdog; a timeout sets sticky err and drops the sweep.
// Ports: clk, rst_n | i2c_end, rd_data from the I2C master | i2c_start, wr_en, rd_en,
//   byte_addr, wr_data to the I2C master | time_out, time_valid, busy, err to the host |
//   set_req, set_data, set_ack runtime set-time handshake.
// Build option: RTC_SETTIME_EN enables the set-time path; without it set_req and
//   set_data are ignored and set_ack is tied low.
module rtc_reg_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned          N_REGS      = 6,
  parameter logic [8*N_REGS-1:0]  REG_ADDRS   = DEF_REG_ADDRS,
  parameter logic [8*N_REGS-1:0]  REG_MASKS   = DEF_REG_MASKS,
  parameter logic [8*N_REGS-1:0]  TIME_INIT   = DEF_TIME_INIT,
  parameter int unsigned          WAIT_CYC    = 8000,
  parameter int unsigned          POLL_CYC    = 1000,
  parameter int unsigned          TIMEOUT_CYC = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2c_end,
  input  logic [7:0]            rd_data,
  output logic                  i2c_start,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [15:0]           byte_addr,
  output logic [7:0]            wr_data,
  output logic [8*N_REGS-1:0]   time_out,
  output logic                  time_valid,
  output logic                  busy,
  output logic                  err,
  input  logic                  set_req,
  input  logic [8*N_REGS-1:0]   set_data,
  output logic                  set_ack
);

  localparam int unsigned IW = idx_width(N_REGS);
  localparam int unsigned TW = cnt_width(WAIT_CYC, POLL_CYC, TIMEOUT_CYC);

  localparam logic [N_REGS-1:0][7:0] ADDR_T = REG_ADDRS;
  localparam logic [N_REGS-1:0][7:0] MASK_T = REG_MASKS;
  localparam logic [N_REGS-1:0][7:0] INIT_T = TIME_INIT;

  rtc_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic src_set_q, src_set_d;  // current write sweep carries set_data, not TIME_INIT
  logic err_q, err_d;
  logic busy_q;
  logic time_valid_q;
  logic [N_REGS-1:0][7:0] shadow_q, snap, time_out_q;

  logic set_go, set_take, set_done, rd_cap, publish, last_idx;
  logic tmr_clr, tmr_en, tmr_exp;
  logic [TW-1:0] tmr_term;
  logic [7:0] wr_byte;

  assign last_idx = (idx_q == IW'(N_REGS - 1));

  // One timer serves the power-up wait, the poll interval and the watchdog;
  // it restarts on every state change so each phase counts from zero.
  always_comb begin
    case (state_q)
      ST_WAIT: tmr_term = TW'(WAIT_CYC - 1);
      ST_IDLE: tmr_term = TW'(POLL_CYC - 1);
      default: tmr_term = TW'(TIMEOUT_CYC - 1);
    endcase
  end

  assign tmr_en  = (state_q == ST_WAIT) || (state_q == ST_IDLE) ||
                   (state_q == ST_WR_BUSY) || (state_q == ST_RD_BUSY);
  assign tmr_clr = (state_d != state_q);

  rtc_cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .term_i   (tmr_term),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_set_d = src_set_q;
    err_d     = err_q;
    set_take  = 1'b0;
    set_done  = 1'b0;
    rd_cap    = 1'b0;
    publish   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (tmr_exp) begin
          state_d   = ST_WR_ISSUE;
          idx_d     = '0;
          src_set_d = 1'b0;
        end
      end
      ST_WR_ISSUE: state_d = ST_WR_BUSY;
      ST_WR_BUSY: begin
        // i2c_end is tested first so a completion beats a same-cycle timeout.
        if (i2c_end) begin
          if (last_idx) begin
            idx_d    = '0;
            state_d  = src_set_q ? ST_IDLE : ST_RD_ISSUE;
            set_done = src_set_q;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_WR_ISSUE;
          end
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A set request outranks a poll expiring in the same cycle.
        if (set_go) begin
          state_d   = ST_WR_ISSUE;
          idx_d     = '0;
          src_set_d = 1'b1;
          set_take  = 1'b1;
        end else if (tmr_exp) begin
          state_d = ST_RD_ISSUE;
          idx_d   = '0;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_BUSY;
      ST_RD_BUSY: begin
        if (i2c_end) begin
          rd_cap = 1'b1;
          if (last_idx) begin
            publish = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD_ISSUE;
          end
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      idx_q     <= '0;
      src_set_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      src_set_q <= src_set_d;
      err_q     <= err_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // The final byte is merged in combinationally so the snapshot published on
  // the last i2c_end already contains it.
  always_comb begin
    snap        = shadow_q;
    snap[idx_q] = rd_data & MASK_T[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      time_out_q   <= '0;
      time_valid_q <= 1'b0;
    end else begin
      if (rd_cap) begin
        shadow_q[idx_q] <= rd_data & MASK_T[idx_q];
      end
      if (publish) begin
        time_out_q <= snap;
      end
      time_valid_q <= publish;
    end
  end

`ifdef RTC_SETTIME_EN
  logic [N_REGS-1:0][7:0] set_buf_q;
  logic set_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_buf_q <= '0;
      set_ack_q <= 1'b0;
    end else begin
      if (set_take) begin
        set_buf_q <= set_data;
      end
      set_ack_q <= set_done;
    end
  end

  assign set_go  = set_req;
  assign set_ack = set_ack_q;
  assign wr_byte = src_set_q ? set_buf_q[idx_q] : INIT_T[idx_q];
`else
  logic unused_set;
  assign unused_set = ^{set_req, set_data, set_take, set_done};
  assign set_go  = 1'b0;
  assign set_ack = 1'b0;
  assign wr_byte = INIT_T[idx_q];
`endif

  assign wr_en      = (state_q == ST_WR_ISSUE) || (state_q == ST_WR_BUSY);
  assign rd_en      = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_BUSY);
  assign i2c_start  = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
  assign byte_addr  = (wr_en || rd_en) ? {8'h00, ADDR_T[idx_q]} : 16'h0000;
  assign wr_data    = wr_en ? wr_byte : 8'h00;
  assign time_out   = time_out_q;
  assign time_valid = time_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
